// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pkg
//  Purpose  : Shared definitions for the seven-segment scan capture path:
//             active-low glyph patterns (g..a order), anode select codes,
//             digit-capture FSM encoding, per-digit slot record and helpers.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package seg7_pkg;

    // Segment patterns, active-low, bit6 = g ... bit0 = a
    localparam logic [6:0] c_SEG_0     = 7'b1000000;
    localparam logic [6:0] c_SEG_1     = 7'b1111001;
    localparam logic [6:0] c_SEG_2     = 7'b0100100;
    localparam logic [6:0] c_SEG_3     = 7'b0110000;
    localparam logic [6:0] c_SEG_4     = 7'b0011001;
    localparam logic [6:0] c_SEG_5     = 7'b0010010;
    localparam logic [6:0] c_SEG_6     = 7'b0000010;
    localparam logic [6:0] c_SEG_7     = 7'b1111000;
    localparam logic [6:0] c_SEG_8     = 7'b0000000;
    localparam logic [6:0] c_SEG_9     = 7'b0010000;
    localparam logic [6:0] c_SEG_A     = 7'b0001000;
    localparam logic [6:0] c_SEG_B     = 7'b0000011;
    localparam logic [6:0] c_SEG_C     = 7'b1000110;
    localparam logic [6:0] c_SEG_D     = 7'b0100001;
    localparam logic [6:0] c_SEG_E     = 7'b0000110;
    localparam logic [6:0] c_SEG_F     = 7'b0001110;
    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;

    // Anode selects, active-low one-hot; digit0 is the rightmost digit
    localparam logic [3:0] c_DIG_SEL0 = 4'b1110;
    localparam logic [3:0] c_DIG_SEL1 = 4'b1101;
    localparam logic [3:0] c_DIG_SEL2 = 4'b1011;
    localparam logic [3:0] c_DIG_SEL3 = 4'b0111;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // One captured digit position
    typedef struct packed {
        logic [3:0] nib;
        logic       is_blank;
        logic       is_err;
    } slot_t;

    function automatic logic dig_valid(input logic [3:0] dig);
        case (dig)
            c_DIG_SEL0, c_DIG_SEL1, c_DIG_SEL2, c_DIG_SEL3: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] dig_index(input logic [3:0] dig);
        case (dig)
            c_DIG_SEL1: return 2'd1;
            c_DIG_SEL2: return 2'd2;
            c_DIG_SEL3: return 2'd3;
            default:    return 2'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_decode
//  Purpose  : Combinational active-low seven-segment glyph decoder.
//  Ports    : i_seg    [6:0] segment pattern, active-low, bit6=g..bit0=a
//             o_nibble [3:0] decoded hex value (0 for blank / unknown)
//             o_blank        all segments off
//             o_err          pattern is not a hex glyph
//  Revision : 1.0  initial release
// ============================================================================
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_nibble,
    output logic       o_blank,
    output logic       o_err
);

    always_comb begin
        o_nibble = 4'h0;
        o_blank  = 1'b0;
        o_err    = 1'b0;
        case (i_seg)
            c_SEG_0:     o_nibble = 4'h0;
            c_SEG_1:     o_nibble = 4'h1;
            c_SEG_2:     o_nibble = 4'h2;
            c_SEG_3:     o_nibble = 4'h3;
            c_SEG_4:     o_nibble = 4'h4;
            c_SEG_5:     o_nibble = 4'h5;
            c_SEG_6:     o_nibble = 4'h6;
            c_SEG_7:     o_nibble = 4'h7;
            c_SEG_8:     o_nibble = 4'h8;
            c_SEG_9:     o_nibble = 4'h9;
            c_SEG_A:     o_nibble = 4'hA;
            c_SEG_B:     o_nibble = 4'hB;
            c_SEG_C:     o_nibble = 4'hC;
            c_SEG_D:     o_nibble = 4'hD;
            c_SEG_E:     o_nibble = 4'hE;
            c_SEG_F:     o_nibble = 4'hF;
            c_SEG_BLANK: o_blank  = 1'b1;
            default:     o_err    = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_capture.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_capture
//  Purpose  : Samples a multiplexed seven-segment scan bus, debounces each
//             scan slot, assembles four-digit frames and commits a frame once
//             MATCH identical frames have been seen in a row.
//  Ports    : clk            system clock
//             rst            asynchronous reset, active-low
//             DIGIT   [3:0]  anode select, active-low one-hot
//             DISPLAY [6:0]  segments, active-low, bit0=a..bit6=g
//             value   [15:0] committed digits, digit0 in [3:0]
//             blank   [3:0]  committed per-digit blank flags
//             err     [3:0]  committed per-digit bad-glyph flags
//             valid          a frame is committed and scanning is alive
//             update         one-cycle pulse when committed outputs change
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int SETTLE  = 4,
    parameter int MATCH   = 2,
    parameter int TIMEOUT = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  DIGIT,
    input  logic [6:0]  DISPLAY,
    output logic [15:0] value,
    output logic [3:0]  blank,
    output logic [3:0]  err,
    output logic        valid,
    output logic        update
);

    localparam int c_SW = $clog2(SETTLE + 1);
    localparam int c_MW = $clog2(MATCH + 1);
    localparam int c_TW = $clog2(TIMEOUT);

    // ---------------- input synchronizer + one-cycle history ---------------
    logic [3:0] r_dig_s1, r_dig_s2, r_dig_q;
    logic [6:0] r_seg_s1, r_seg_s2, r_seg_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dig_s1 <= 4'hF;
            r_dig_s2 <= 4'hF;
            r_dig_q  <= 4'hF;
            r_seg_s1 <= c_SEG_BLANK;
            r_seg_s2 <= c_SEG_BLANK;
            r_seg_q  <= c_SEG_BLANK;
        end else begin
            r_dig_s1 <= DIGIT;
            r_dig_s2 <= r_dig_s1;
            r_dig_q  <= r_dig_s2;
            r_seg_s1 <= DISPLAY;
            r_seg_s2 <= r_seg_s1;
            r_seg_q  <= r_seg_s2;
        end
    end

    logic w_dig_chg, w_any_chg, w_dig_ok;
    assign w_dig_chg = (r_dig_s2 != r_dig_q);
    assign w_any_chg = w_dig_chg || (r_seg_s2 != r_seg_q);
    assign w_dig_ok  = dig_valid(r_dig_s2);

    // ---------------- digit capture FSM ------------------------------------
    state_t            r_state, w_state_nxt;
    logic [c_SW-1:0]   r_stab_cnt;
    logic              w_settled, w_accept, w_cnt_clr, w_cnt_inc;

    assign w_settled = (r_stab_cnt == c_SW'(SETTLE - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_WAIT;
        else      r_state <= w_state_nxt;
    end

    // A change seen in SETTLE or HOLD passes through WAIT in zero time: a
    // valid new code starts its stability count on the very cycle it appears.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_WAIT:   if (w_dig_ok) w_state_nxt = ST_SETTLE;
            ST_SETTLE: begin
                if (w_any_chg)      w_state_nxt = w_dig_ok ? ST_SETTLE : ST_WAIT;
                else if (w_settled) w_state_nxt = ST_HOLD;
            end
            ST_HOLD:   if (w_dig_chg) w_state_nxt = w_dig_ok ? ST_SETTLE : ST_WAIT;
            default:   w_state_nxt = ST_WAIT;
        endcase
    end

    always_comb begin
        w_cnt_clr = 1'b1;
        w_cnt_inc = 1'b0;
        w_accept  = 1'b0;
        if (r_state == ST_SETTLE && !w_any_chg) begin
            w_cnt_clr = 1'b0;
            w_cnt_inc = 1'b1;
            w_accept  = w_settled;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           r_stab_cnt <= '0;
        else if (w_cnt_clr) r_stab_cnt <= '0;
        else if (w_cnt_inc) r_stab_cnt <= r_stab_cnt + 1'b1;
    end

    // ---------------- glyph decode of the synchronized segments ------------
    logic [3:0] w_nib;
    logic       w_blk, w_err;

    seg7_decode u_decode (
        .i_seg    (r_seg_s2),
        .o_nibble (w_nib),
        .o_blank  (w_blk),
        .o_err    (w_err)
    );

    // ---------------- frame assembly ---------------------------------------
    slot_t [3:0]      r_shadow, r_prev, w_shadow_nxt;
    logic  [3:0]      r_seen, w_seen_nxt;
    logic  [c_MW-1:0] r_match, w_match_nxt;
    logic  [c_TW-1:0] r_idle;
    logic  [15:0]     r_value, w_cval;
    logic  [3:0]      r_blank, r_err, w_cblk, w_cerr;
    logic             r_valid, r_update;
    logic             w_complete, w_commit, w_differs, w_timeout;
    logic  [1:0]      w_idx;
    slot_t            w_slot;

    always_comb begin
        w_idx        = dig_index(r_dig_s2);
        w_slot.nib      = w_nib;
        w_slot.is_blank = w_blk;
        w_slot.is_err   = w_err;
        w_shadow_nxt = r_shadow;
        w_seen_nxt   = r_seen;
        if (w_accept) begin
            w_shadow_nxt[w_idx] = w_slot;
            w_seen_nxt          = r_seen | (4'b0001 << w_idx);
        end
        w_complete = w_accept && (w_seen_nxt == 4'hF);

        if (w_shadow_nxt != r_prev)
            w_match_nxt = c_MW'(1);
        else if (r_match == c_MW'(MATCH))
            w_match_nxt = r_match;
        else
            w_match_nxt = r_match + 1'b1;
        w_commit = w_complete && (w_match_nxt == c_MW'(MATCH));

        // On a commit the new previous-frame buffer equals w_shadow_nxt
        w_cval = '0;
        w_cblk = '0;
        w_cerr = '0;
        for (int i = 0; i < 4; i++) begin
            w_cval[i*4 +: 4] = w_shadow_nxt[i].nib;
            w_cblk[i]        = w_shadow_nxt[i].is_blank;
            w_cerr[i]        = w_shadow_nxt[i].is_err;
        end
        w_differs = (w_cval != r_value) || (w_cblk != r_blank) || (w_cerr != r_err);
        w_timeout = (r_idle == c_TW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shadow <= '0;
            r_prev   <= '0;
            r_seen   <= '0;
            r_match  <= '0;
            r_idle   <= '0;
            r_value  <= '0;
            r_blank  <= 4'hF;
            r_err    <= '0;
            r_valid  <= 1'b0;
            r_update <= 1'b0;
        end else begin
            r_update <= 1'b0;
            if (w_accept) begin
                // Accept wins over a coincident timeout
                r_idle   <= '0;
                r_shadow <= w_shadow_nxt;
                if (w_complete) begin
                    r_seen  <= '0;
                    r_prev  <= w_shadow_nxt;
                    r_match <= w_match_nxt;
                    if (w_commit) begin
                        r_value  <= w_cval;
                        r_blank  <= w_cblk;
                        r_err    <= w_cerr;
                        r_update <= !r_valid || w_differs;
                        r_valid  <= 1'b1;
                    end
                end else begin
                    r_seen <= w_seen_nxt;
                end
            end else if (w_timeout) begin
                // Idle counter parks at its terminal value until the next accept
                r_valid <= 1'b0;
                r_seen  <= '0;
                r_match <= '0;
            end else begin
                r_idle <= r_idle + 1'b1;
            end
        end
    end

    assign value  = r_value;
    assign blank  = r_blank;
    assign err    = r_err;
    assign valid  = r_valid;
    assign update = r_update;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_capture
//  Purpose  : Directed self-checking bench for seg7_scan_capture.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_scan_capture;

    localparam int c_TIMEOUT = 1024;
    localparam int c_SLOT    = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  dig;
    logic [6:0]  seg;
    logic [15:0] value;
    logic [3:0]  blank;
    logic [3:0]  err;
    logic        valid;
    logic        update;

    int n_checks = 0;
    int n_fail   = 0;
    int n_upd    = 0;
    int upd_base;

    always #5 clk = ~clk;

    seg7_scan_capture #(
        .SETTLE  (4),
        .MATCH   (2),
        .TIMEOUT (c_TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .DIGIT   (dig),
        .DISPLAY (seg),
        .value   (value),
        .blank   (blank),
        .err     (err),
        .valid   (valid),
        .update  (update)
    );

    // Counts cycles with update high, so a stretched pulse counts twice
    always @(negedge clk) if (update === 1'b1) n_upd++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    task automatic scan_slot(input logic [3:0] d, input logic [6:0] s, input int cyc);
        dig = d;
        seg = s;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic scan_frame(input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0, input int cyc);
        scan_slot(4'b1110, s0, cyc);
        scan_slot(4'b1101, s1, cyc);
        scan_slot(4'b1011, s2, cyc);
        scan_slot(4'b0111, s3, cyc);
    endtask

    task automatic scan_hex(input logic [15:0] h, input int cyc, input int frames);
        for (int f = 0; f < frames; f++)
            scan_frame(glyph(h[15:12]), glyph(h[11:8]), glyph(h[7:4]), glyph(h[3:0]), cyc);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_value"},  32'(value),  32'h0);
        chk({tag, "_blank"},  32'(blank),  32'hF);
        chk({tag, "_err"},    32'(err),    32'h0);
        chk({tag, "_valid"},  32'(valid),  32'h0);
        chk({tag, "_update"}, 32'(update), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        dig = 4'hF;
        seg = 7'h7F;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Slots of 3 and of exactly SETTLE cycles never capture
        upd_base = n_upd;
        scan_hex(16'h12AF, 3, 3);
        scan_slot(4'hF, 7'h7F, 10);
        chk("short3_valid", 32'(valid), 32'h0);
        chk("short3_upd",   32'(n_upd - upd_base), 32'h0);
        scan_hex(16'h12AF, 4, 3);
        scan_slot(4'hF, 7'h7F, 10);
        chk("short4_valid", 32'(valid), 32'h0);
        chk("short4_upd",   32'(n_upd - upd_base), 32'h0);

        // "12AF": commit after the second frame, one update overall
        upd_base = n_upd;
        scan_hex(16'h12AF, c_SLOT, 1);
        chk("f1_valid", 32'(valid), 32'h0);
        scan_hex(16'h12AF, c_SLOT, 1);
        chk("f2_valid", 32'(valid), 32'h1);
        chk("f2_value", 32'(value), 32'h12AF);
        chk("f2_blank", 32'(blank), 32'h0);
        chk("f2_err",   32'(err),   32'h0);
        scan_hex(16'h12AF, c_SLOT, 1);
        chk("f3_upd",   32'(n_upd - upd_base), 32'h1);
        chk("f3_value", 32'(value), 32'h12AF);

        // Switch to "12AE": first new frame only arms the match count
        scan_hex(16'h12AE, c_SLOT, 1);
        chk("e1_value", 32'(value), 32'h12AF);
        chk("e1_upd",   32'(n_upd - upd_base), 32'h1);
        scan_hex(16'h12AE, c_SLOT, 1);
        chk("e2_value", 32'(value), 32'h12AE);
        chk("e2_upd",   32'(n_upd - upd_base), 32'h2);
        chk("e2_valid", 32'(valid), 32'h1);

        // Stop scanning: valid survives until TIMEOUT idle cycles, then drops
        upd_base = n_upd;
        scan_slot(4'hF, 7'h7F, 900);
        chk("to_before_valid", 32'(valid), 32'h1);
        scan_slot(4'hF, 7'h7F, 200);
        chk("to_after_valid", 32'(valid), 32'h0);
        chk("to_value",       32'(value), 32'h12AE);
        chk("to_blank",       32'(blank), 32'h0);
        chk("to_upd",         32'(n_upd - upd_base), 32'h0);

        // Bad glyph on digit2, others blank
        upd_base = n_upd;
        scan_frame(7'h7F, 7'b1010101, 7'h7F, 7'h7F, c_SLOT);
        chk("bad1_valid", 32'(valid), 32'h0);
        scan_frame(7'h7F, 7'b1010101, 7'h7F, 7'h7F, c_SLOT);
        chk("bad2_err",   32'(err),   32'h4);
        chk("bad2_blank", 32'(blank), 32'hB);
        chk("bad2_value", 32'(value), 32'h0);
        chk("bad2_valid", 32'(valid), 32'h1);
        chk("bad2_upd",   32'(n_upd - upd_base), 32'h1);

        // Reset in the middle of a "0000" frame
        scan_slot(4'b1110, glyph(4'h0), c_SLOT);
        scan_slot(4'b1101, glyph(4'h0), c_SLOT);
        rst = 1'b0;
        dig = 4'hF;
        seg = 7'h7F;
        repeat (3) @(negedge clk);
        chk_reset_vals("mid_rst");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        upd_base = n_upd;
        scan_hex(16'h0000, c_SLOT, 1);
        chk("z1_valid", 32'(valid), 32'h0);
        scan_hex(16'h0000, c_SLOT, 1);
        chk("z2_valid", 32'(valid), 32'h1);
        chk("z2_value", 32'(value), 32'h0);
        chk("z2_blank", 32'(blank), 32'h0);
        chk("z2_err",   32'(err),   32'h0);
        chk("z2_upd",   32'(n_upd - upd_base), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
